uart_tx_scheduler: RTL and testbench
====================================

// Module: uart_tx_scheduler
// PURPOSE
//  Round-robin scheduler that shares one uart_transmitter among N_CLIENTS byte producers.
//  Picks one requester, hands its byte to the transmitter via the Tx_WR/Tx_BUSY handshake,
//  acks the client, and waits for the frame to finish before the next grant.
//  Sits between client logic and uart_transmitter; drives its Tx_DATA, Tx_WR and Tx_EN.
// PARAMETERS
//  N_CLIENTS     4      number of requesters, legal range 2..8
//  BUSY_TIMEOUT  16     cycles after Tx_WR to wait for Tx_BUSY to rise before aborting
//  TAG_BASE      8'hF0  tag byte base; the tag sent is TAG_BASE | client_id (UART_TXS_TAG_EN only)
// PORTS
//  clk          in   1            system clock
//  reset        in   1            synchronous, active-high reset
//  arb_en       in   1            enables new grants
//  req          in   N_CLIENTS    per-client request; hold high with data stable until ack
//  data_in      in   8*N_CLIENTS  client i byte in data_in[8*i+7:8*i]
//  ack          out  N_CLIENTS    one-cycle pulse when client i's byte is latched
//  grant_id     out  3            client currently owning the link
//  sched_busy   out  1            high whenever state != IDLE
//  timeout_err  out  1            one-cycle pulse when Tx_BUSY fails to rise in time
//  Tx_DATA      out  8            byte to the transmitter, registered
//  Tx_WR        out  1            one-cycle write strobe to the transmitter
//  Tx_EN        out  1            transmitter enable = arb_en | sched_busy
//  Tx_BUSY      in   1            transmitter busy flag
// BEHAVIOUR
//  - Reset values: ack=0, grant_id=0, sched_busy=0, timeout_err=0, Tx_DATA=8'h00, Tx_WR=0.
//    Round-robin pointer resets to N_CLIENTS-1, so client 0 has the highest priority first.
//    Reset mid-frame aborts immediately; Tx_WR is never reasserted until a new grant.
//  - FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
//  - IDLE: when arb_en=1 and req!=0, grant the first requester after the pointer (cyclic).
//    Register grant_id, update the pointer to the winner, and go to ISSUE.
//  - ISSUE (1 cycle): Tx_DATA<=data_in[winner], Tx_WR=1, ack[winner]=1, then go to WAIT_BUSY.
//    If req[winner] has dropped, go back to IDLE with no write and no ack.
//  - WAIT_BUSY: leave for WAIT_DONE on Tx_BUSY=1. If Tx_BUSY is still 0 after BUSY_TIMEOUT
//    cycles, pulse timeout_err and go to IDLE (the pointer has already advanced).
//  - WAIT_DONE: go to IDLE on Tx_BUSY=0. A new grant is possible in the following cycle.
//  - Latency: req to Tx_WR is 2 cycles. ack is coincident with Tx_WR.
//  - Simultaneous requests are served in cyclic order. A client holding req continuously gets
//    at most one byte per round while others are requesting.
//  - Deasserting arb_en mid-frame does not abort; the frame completes and Tx_EN stays high
//    until IDLE.
//  - Requests arriving while not in IDLE are ignored until the scheduler returns to IDLE.
// CONFIGURATION
//  UART_TXS_TAG_EN defined:
//  - Each grant first sends the tag byte TAG_BASE|grant_id through the full
//    ISSUE/WAIT_BUSY/WAIT_DONE cycle, then sends the data byte (a phase flag selects which).
//  - ack fires only on the data-byte ISSUE; the data byte is latched at that moment.
//  - Dropping req between tag and data: go to IDLE with no data byte and no ack.
//  - A timeout on the tag aborts the whole pair.
//  UART_TXS_TAG_EN undefined: data bytes only; no phase flag and no TAG_BASE logic.
// STRUCTURE
//  - Shared package/header uart_pkg: FSM state encodings, TXS_MAX_CLIENTS=8, TAG_BASE default.
//  - Sub-module rr_picker: combinational cyclic priority picker that takes (req, pointer) and
//    returns (valid, id).
//  - The timeout counter stays inline: $clog2(BUSY_TIMEOUT+1) bits, cleared on entry to
//    WAIT_BUSY.
// TESTING  (bench connects to uart_transmitter with baud_select=3'b111)
//  1. Reset: hold reset 5 cycles. All outputs must be 0 and no Tx_WR may occur while req=0.
//  2. Single client: req[1]=1, data=8'hAA. Expect ack[1] and Tx_WR in the same cycle,
//     Tx_DATA=8'hAA, one frame on TxD, a loopback receiver reading AA, grant_id=1.
//  3. Fairness: req=4'b1111 with bytes 11/22/33/44 held high. Transmit order must be
//     11, 22, 33, 44, 11, ... with exactly one ack per frame.
//  4. Timeout: tie Tx_BUSY to 0 and request client 2. Expect timeout_err 16 cycles after
//     Tx_WR, a return to IDLE, and the next grant going to client 3 when requested.
//  5. arb_en: drop arb_en mid-frame. The frame completes, no new grant occurs, and Tx_EN
//     falls after Tx_BUSY falls. Reset asserted mid-frame yields Tx_WR=0 and IDLE.
//  6. Tag mode (UART_TXS_TAG_EN): client 3 sends 8'h89. Expect F3 then 89 on the line, with
//     ack only on the 89 write. Dropping req after the tag yields no data byte and no ack.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmit scheduler
package uart_pkg;
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_BUSY,
      ST_WAIT_DONE
   } txs_state_t;

   localparam int TXS_MAX_CLIENTS = 8;
   localparam int TXS_ID_W = $clog2(TXS_MAX_CLIENTS);
   localparam logic [7:0] TXS_TAG_BASE = 8'hF0;
endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational cyclic priority picker: first requester after ptr
module rr_picker
   import uart_pkg::*;
#(
   parameter int N_CLIENTS = 4
) (
   input  logic [N_CLIENTS-1:0] req,
   input  logic [TXS_ID_W-1:0]  ptr,
   output logic                 valid,
   output logic [TXS_ID_W-1:0]  id
);

   // Outer loop walks distance from the pointer, so the nearest requester wins.
   always_comb begin
      valid = 1'b0;
      id    = '0;
      for (int k = 1; k <= N_CLIENTS; k++) begin
         for (int c = 0; c < N_CLIENTS; c++) begin
            if (!valid && req[c] && (c == ((int'(ptr) + k) % N_CLIENTS))) begin
               valid = 1'b1;
               id    = TXS_ID_W'(c);
            end
         end
      end
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin sharing of one UART transmitter among N clients
// Optional UART_TXS_TAG_EN: precede every data byte with tag byte TAG_BASE | grant_id.
module uart_tx_scheduler
   import uart_pkg::*;
#(
   parameter int N_CLIENTS    = 4,
   parameter int BUSY_TIMEOUT = 16
`ifdef UART_TXS_TAG_EN
   ,
   parameter logic [7:0] TAG_BASE = TXS_TAG_BASE
`endif
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   arb_en,
   input  logic [N_CLIENTS-1:0]   req,
   input  logic [8*N_CLIENTS-1:0] data_in,
   output logic [N_CLIENTS-1:0]   ack,
   output logic [2:0]             grant_id,
   output logic                   sched_busy,
   output logic                   timeout_err,
   output logic [7:0]             Tx_DATA,
   output logic                   Tx_WR,
   output logic                   Tx_EN,
   input  logic                   Tx_BUSY
);

   localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

   txs_state_t                 state;
   logic [TXS_ID_W-1:0]        ptr;
   logic [CNT_W-1:0]           cnt;
   logic                       pick_valid;
   logic [TXS_ID_W-1:0]        pick_id;
   logic [N_CLIENTS-1:0]       ack_onehot;
   logic [TXS_MAX_CLIENTS-1:0] req_ext;
   logic [7:0]                 bytes [TXS_MAX_CLIENTS];
`ifdef UART_TXS_TAG_EN
   logic                       phase;
`endif

   // Widen to the full id space so a 3-bit grant_id indexes without truncation.
   for (genvar g = 0; g < TXS_MAX_CLIENTS; g++) begin : g_ext
      if (g < N_CLIENTS) begin : g_used
         assign bytes[g]   = data_in[8*g +: 8];
         assign req_ext[g] = req[g];
      end else begin : g_pad
         assign bytes[g]   = 8'h00;
         assign req_ext[g] = 1'b0;
      end
   end

   always_comb begin
      ack_onehot = '0;
      for (int i = 0; i < N_CLIENTS; i++) begin
         ack_onehot[i] = (grant_id == TXS_ID_W'(i));
      end
   end

   rr_picker #(.N_CLIENTS(N_CLIENTS)) u_picker (
      .req   (req),
      .ptr   (ptr),
      .valid (pick_valid),
      .id    (pick_id)
   );

   assign sched_busy = (state != ST_IDLE);
   assign Tx_EN      = arb_en | sched_busy;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         ptr         <= TXS_ID_W'(N_CLIENTS - 1);
         grant_id    <= '0;
         ack         <= '0;
         timeout_err <= 1'b0;
         Tx_DATA     <= 8'h00;
         Tx_WR       <= 1'b0;
         cnt         <= '0;
`ifdef UART_TXS_TAG_EN
         phase       <= 1'b0;
`endif
      end else begin
         ack         <= '0;
         Tx_WR       <= 1'b0;
         timeout_err <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (arb_en && pick_valid) begin
                  grant_id <= pick_id;
                  ptr      <= pick_id;
`ifdef UART_TXS_TAG_EN
                  phase    <= 1'b0;
`endif
                  state    <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (!req_ext[grant_id]) begin
                  state <= ST_IDLE;
               end else begin
                  Tx_WR <= 1'b1;
                  cnt   <= '0;
                  state <= ST_WAIT_BUSY;
`ifdef UART_TXS_TAG_EN
                  if (!phase) begin
                     Tx_DATA <= TAG_BASE | 8'(grant_id);
                  end else begin
                     Tx_DATA <= bytes[grant_id];
                     ack     <= ack_onehot;
                  end
`else
                  Tx_DATA <= bytes[grant_id];
                  ack     <= ack_onehot;
`endif
               end
            end
            ST_WAIT_BUSY: begin
               if (Tx_BUSY) begin
                  state <= ST_WAIT_DONE;
               end else if (cnt == CNT_LAST) begin
                  timeout_err <= 1'b1;
                  state       <= ST_IDLE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_WAIT_DONE: begin
               if (!Tx_BUSY) begin
`ifdef UART_TXS_TAG_EN
                  if (!phase) begin
                     phase <= 1'b1;
                     state <= ST_ISSUE;
                  end else begin
                     state <= ST_IDLE;
                  end
`else
                  state <= ST_IDLE;
`endif
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - directed bench for uart_tx_scheduler with a simple transmitter model
// Define UART_TXS_TAG_EN to run the tag-mode sequences instead of the data-only ones.
module tb_uart_tx_scheduler;

   logic        clk = 1'b0;
   logic        reset;
   logic        arb_en;
   logic [3:0]  req;
   logic [31:0] data_in;
   logic [3:0]  ack;
   logic [2:0]  grant_id;
   logic        sched_busy;
   logic        timeout_err;
   logic [7:0]  Tx_DATA;
   logic        Tx_WR;
   logic        Tx_EN;
   logic        Tx_BUSY;

   int n_checks = 0;
   int n_fail   = 0;
   int n_wr     = 0;
   int n_ack    = 0;
   int n_ack_nowr = 0;
   logic stuck;
   int   frame_cnt;

   localparam int FRAME = 8;

   always #5 clk = ~clk;

   uart_tx_scheduler dut (
      .clk         (clk),
      .reset       (reset),
      .arb_en      (arb_en),
      .req         (req),
      .data_in     (data_in),
      .ack         (ack),
      .grant_id    (grant_id),
      .sched_busy  (sched_busy),
      .timeout_err (timeout_err),
      .Tx_DATA     (Tx_DATA),
      .Tx_WR       (Tx_WR),
      .Tx_EN       (Tx_EN),
      .Tx_BUSY     (Tx_BUSY)
   );

   // Transmitter stand-in: busy rises the cycle after Tx_WR and holds for FRAME cycles.
   always @(posedge clk) begin
      if (reset) begin
         Tx_BUSY   <= 1'b0;
         frame_cnt <= 0;
      end else if (!stuck && Tx_WR) begin
         Tx_BUSY   <= 1'b1;
         frame_cnt <= FRAME;
      end else if (Tx_BUSY) begin
         frame_cnt <= frame_cnt - 1;
         if (frame_cnt == 1) Tx_BUSY <= 1'b0;
      end
   end

   always @(negedge clk) begin
      if (Tx_WR) n_wr++;
      if (|ack) n_ack++;
      if (|ack && !Tx_WR) n_ack_nowr++;
   end

   typedef struct {
      logic [3:0]  req;
      logic [31:0] data;
      logic [2:0]  exp_id;
      logic [7:0]  exp_byte;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_wr(input int budget, output int cyc);
      cyc = 0;
      while (cyc < budget) begin
         tick();
         cyc++;
         if (Tx_WR) return;
      end
      cyc = -1;
   endtask

   task automatic wait_idle(input int budget, output int ok);
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (!sched_busy) begin
            ok = 1;
            return;
         end
      end
   endtask

   task automatic do_reset(input int cycles);
      reset = 1'b1;
      repeat (cycles) tick();
      reset = 1'b0;
   endtask

   initial begin
      int cyc;
      int ok;
      int wr_before;
      int ack_before;
      logic [3:0] exp_ack;
      logic [7:0] fair [5];

      vecs[0] = '{4'b0010, 32'h0000AA00, 3'd1, 8'hAA};
      vecs[1] = '{4'b0100, 32'h00CC0000, 3'd2, 8'hCC};
      vecs[2] = '{4'b1001, 32'h5A0000A5, 3'd3, 8'h5A};
      vecs[3] = '{4'b1001, 32'h5A0000A5, 3'd0, 8'hA5};
      vecs[4] = '{4'b0110, 32'h003CC300, 3'd1, 8'hC3};
      vecs[5] = '{4'b1111, 32'h44332211, 3'd2, 8'h33};
      fair    = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};

      reset = 1'b1; arb_en = 1'b1; req = '0; data_in = '0; stuck = 1'b0;
      #1;
      do_reset(5);
      check("rst_ack", 32'(ack), 0);
      check("rst_grant_id", 32'(grant_id), 0);
      check("rst_sched_busy", 32'(sched_busy), 0);
      check("rst_timeout_err", 32'(timeout_err), 0);
      check("rst_tx_data", 32'(Tx_DATA), 0);
      check("rst_tx_wr", 32'(Tx_WR), 0);
      repeat (5) tick();
      check("idle_no_wr", 32'(n_wr), 0);

`ifndef UART_TXS_TAG_EN
      for (int v = 0; v < 6; v++) begin
         req = vecs[v].req;
         data_in = vecs[v].data;
         exp_ack = 4'b0001 << vecs[v].exp_id;
         wait_wr(10, cyc);
         check($sformatf("v%0d_latency", v), 32'(cyc), 2);
         check($sformatf("v%0d_grant_id", v), 32'(grant_id), 32'(vecs[v].exp_id));
         check($sformatf("v%0d_tx_data", v), 32'(Tx_DATA), 32'(vecs[v].exp_byte));
         check($sformatf("v%0d_ack", v), 32'(ack), 32'(exp_ack));
         req = '0;
         wait_idle(50, ok);
         check($sformatf("v%0d_idle", v), 32'(ok), 1);
      end

      // Fairness from a fresh pointer: all four held high.
      do_reset(2);
      req = 4'b1111;
      data_in = 32'h44332211;
      for (int k = 0; k < 5; k++) begin
         wait_wr(40, cyc);
         check($sformatf("fair%0d_seen", k), 32'(cyc > 0), 1);
         check($sformatf("fair%0d_data", k), 32'(Tx_DATA), 32'(fair[k]));
         check($sformatf("fair%0d_ack", k), 32'(ack), 32'(4'b0001 << (k % 4)));
      end
      req = '0;
      wait_idle(50, ok);
      check("fair_idle", 32'(ok), 1);
      check("ack_per_write", 32'(n_ack), 32'(n_wr));
      check("ack_without_wr", 32'(n_ack_nowr), 0);

      // Timeout: transmitter never raises busy. Pointer sits at client 0.
      stuck = 1'b1;
      req = 4'b0100;
      data_in = 32'h00770000;
      wait_wr(10, cyc);
      check("to_grant_id", 32'(grant_id), 2);
      req = '0;
      cyc = -1;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (timeout_err) begin
            cyc = k;
            break;
         end
      end
      check("to_delay", 32'(cyc), 16);
      check("to_back_idle", 32'(sched_busy), 0);
      tick();
      check("to_pulse_one_cycle", 32'(timeout_err), 0);
      stuck = 1'b0;
      req = 4'b1101;
      data_in = 32'h99880066;
      wait_wr(10, cyc);
      check("to_next_grant", 32'(grant_id), 3);
      check("to_next_data", 32'(Tx_DATA), 32'h99);
      req = '0;
      wait_idle(50, ok);

      // arb_en dropped mid-frame: frame completes, no new grant.
      req = 4'b0010;
      data_in = 32'h0000BB00;
      wait_wr(10, cyc);
      arb_en = 1'b0;
      tick(); tick();
      check("arb_busy_seen", 32'(Tx_BUSY), 1);
      check("arb_tx_en_held", 32'(Tx_EN), 1);
      wait_idle(50, ok);
      check("arb_idle", 32'(ok), 1);
      check("arb_busy_fell_first", 32'(Tx_BUSY), 0);
      check("arb_tx_en_low", 32'(Tx_EN), 0);
      wr_before = n_wr;
      repeat (20) tick();
      check("arb_no_new_grant", 32'(n_wr - wr_before), 0);
      check("arb_still_idle", 32'(sched_busy), 0);

      // Reset in the middle of a frame.
      arb_en = 1'b1;
      req = 4'b0001;
      data_in = 32'h000000DD;
      wait_wr(10, cyc);
      tick(); tick(); tick();
      reset = 1'b1;
      req = '0;
      tick();
      check("mrst_tx_wr", 32'(Tx_WR), 0);
      check("mrst_idle", 32'(sched_busy), 0);
      check("mrst_ack", 32'(ack), 0);
      reset = 1'b0;
      wr_before = n_wr;
      repeat (10) tick();
      check("mrst_no_rewrite", 32'(n_wr - wr_before), 0);
`else
      // Tag mode: client 3 sends 89, preceded by tag F3.
      req = 4'b1000;
      data_in = 32'h89000000;
      wait_wr(10, cyc);
      check("tag_latency", 32'(cyc), 2);
      check("tag_byte", 32'(Tx_DATA), 32'hF3);
      check("tag_no_ack", 32'(ack), 0);
      wait_wr(60, cyc);
      check("tag_data_seen", 32'(cyc > 0), 1);
      check("tag_data_byte", 32'(Tx_DATA), 32'h89);
      check("tag_data_ack", 32'(ack), 32'h8);
      req = '0;
      wait_idle(50, ok);
      check("tag_idle", 32'(ok), 1);
      check("tag_writes", 32'(n_wr), 2);
      check("tag_acks", 32'(n_ack), 1);

      // Dropping req after the tag leaves no data byte and no ack.
      wr_before = n_wr;
      ack_before = n_ack;
      req = 4'b1000;
      wait_wr(10, cyc);
      check("tagdrop_tag", 32'(Tx_DATA), 32'hF3);
      req = '0;
      wait_idle(50, ok);
      check("tagdrop_idle", 32'(ok), 1);
      repeat (5) tick();
      check("tagdrop_writes", 32'(n_wr - wr_before), 1);
      check("tagdrop_acks", 32'(n_ack - ack_before), 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
